// File: rtl/alu_pkg.sv
// Shared types for the ALU engine: opcode and FSM state encodings.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_MUL   = 3'd5,
        OP_PASSA = 3'd6,
        OP_RSVD  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int LAT_SINGLE = 1;

endpackage

// File: rtl/alu_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, fixed WIDTH-cycle latency.
module alu_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] addend;

    // product is the accumulator after the current iteration; it is final when done is high
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = (cnt == CNT_W'(1));

    always_ff @(posedge clock) begin
        if (!resetr) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, operand_a};
            mplier <= operand_b;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_engine.sv
// ALU responder: accepts one op when idle, returns a registered result with a one-cycle done pulse.
//   state   | meaning
//   IDLE    | waiting for op_valid; only state that accepts a request
//   MUL     | iterative multiply in progress
//   DONE    | result presented with operation_done; still busy
module alu_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetr,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    input  logic [2:0]           operand,
    input  logic                 op_valid,
    output logic                 operation_done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 op_error,
    output logic                 op_dropped
);

    state_e             state;
    alu_op_e            op;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] single_res;
    logic               single_err;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign op    = alu_op_e'(operand);
    assign a_ext = {{WIDTH{1'b0}}, operand_a};
    assign b_ext = {{WIDTH{1'b0}}, operand_b};

    // SUB on zero-extended operands yields the sign-extended two's complement difference
    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (op)
            OP_ADD:   single_res = a_ext + b_ext;
            OP_SUB:   single_res = a_ext - b_ext;
            OP_AND:   single_res = a_ext & b_ext;
            OP_OR:    single_res = a_ext | b_ext;
            OP_XOR:   single_res = a_ext ^ b_ext;
            OP_PASSA: single_res = a_ext;
            OP_RSVD:  single_err = 1'b1;
            default:  single_res = '0;
        endcase
    end

    assign mul_start = (state == ST_IDLE) && op_valid && (op == OP_MUL);

    alu_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clock     (clock),
        .resetr    (resetr),
        .start     (mul_start),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_ff @(posedge clock) begin
        if (!resetr) begin
            state          <= ST_IDLE;
            operation_done <= 1'b0;
            result         <= '0;
            busy           <= 1'b0;
            op_error       <= 1'b0;
            op_dropped     <= 1'b0;
        end else begin
            operation_done <= 1'b0;
            op_dropped     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        busy <= 1'b1;
                        if (op == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            state          <= ST_DONE;
                            result         <= single_res;
                            op_error       <= single_err;
                            operation_done <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    op_dropped <= op_valid;
                    if (mul_done) begin
                        state          <= ST_DONE;
                        result         <= mul_product;
                        op_error       <= 1'b0;
                        operation_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    op_dropped <= op_valid;
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_engine.sv
// Directed bench for alu_engine: table of single-cycle ops plus multiply, drop and reset sequences.
module tb_alu_engine;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic                 clock;
    logic                 resetr;
    logic [WIDTH-1:0]     operand_a;
    logic [WIDTH-1:0]     operand_b;
    logic [2:0]           operand;
    logic                 op_valid;
    logic                 operation_done;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 op_error;
    logic                 op_dropped;

    int total = 0;
    int bad   = 0;

    alu_engine #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .resetr         (resetr),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .operand        (operand),
        .op_valid       (op_valid),
        .operation_done (operation_done),
        .result         (result),
        .busy           (busy),
        .op_error       (op_error),
        .op_dropped     (op_dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        operand   = op;
        operand_a = a;
        operand_b = b;
        op_valid  = 1'b1;
    endtask

    // Accepts a MUL, scrambles the operands, and expects done exactly WIDTH edges later.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n;
        drive(3'(OP_MUL), a, b);
        tick();
        op_valid  = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
        check("mul_busy_start", 32'(busy), 32'd1);
        n = 0;
        while (!operation_done && n < 30) begin
            tick();
            n++;
        end
        check("mul_latency", 32'(n), 32'(WIDTH));
        check("mul_result", 32'(result), 32'(exp));
        check("mul_err", 32'(op_error), 32'd0);
        tick();
        check("mul_done_pulse", 32'(operation_done), 32'd0);
        check("mul_busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int done_seen;

        vecs[0]  = '{3'(OP_ADD),   8'hFF, 8'h01, 16'h0100, 1'b0};
        vecs[1]  = '{3'(OP_ADD),   8'h12, 8'h34, 16'h0046, 1'b0};
        vecs[2]  = '{3'(OP_SUB),   8'h00, 8'h01, 16'hFFFF, 1'b0};
        vecs[3]  = '{3'(OP_SUB),   8'h50, 8'h20, 16'h0030, 1'b0};
        vecs[4]  = '{3'(OP_AND),   8'hF0, 8'h3C, 16'h0030, 1'b0};
        vecs[5]  = '{3'(OP_OR),    8'hF0, 8'h0F, 16'h00FF, 1'b0};
        vecs[6]  = '{3'(OP_XOR),   8'hAA, 8'hFF, 16'h0055, 1'b0};
        vecs[7]  = '{3'(OP_PASSA), 8'h5A, 8'hC3, 16'h005A, 1'b0};
        vecs[8]  = '{3'(OP_RSVD),  8'h77, 8'h88, 16'h0000, 1'b1};
        vecs[9]  = '{3'(OP_ADD),   8'h01, 8'h01, 16'h0002, 1'b0};
        vecs[10] = '{3'(OP_SUB),   8'h05, 8'h07, 16'hFFFE, 1'b0};

        resetr    = 1'b0;
        operand   = 3'd0;
        operand_a = 8'h00;
        operand_b = 8'h00;
        op_valid  = 1'b0;

        // Reset held for 3 cycles with a request present: nothing may start.
        drive(3'(OP_ADD), 8'h11, 8'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_result", 32'(result), 32'd0);
            check("rst_done", 32'(operation_done), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_dropped", 32'(op_dropped), 32'd0);
        end
        op_valid = 1'b0;
        resetr   = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            repeat (LAT_SINGLE) tick();
            op_valid = 1'b0;
            check("vec_done", 32'(operation_done), 32'd1);
            check("vec_result", 32'(result), 32'(vecs[i].res));
            check("vec_err", 32'(op_error), 32'(vecs[i].err));
            check("vec_busy", 32'(busy), 32'd1);
            tick();
            check("vec_done_low", 32'(operation_done), 32'd0);
            check("vec_busy_low", 32'(busy), 32'd0);
            check("vec_result_hold", 32'(result), 32'(vecs[i].res));
        end

        run_mul(8'hFF, 8'hFF, 16'hFE01);
        run_mul(8'h0C, 8'h00, 16'h0000);
        run_mul(8'h0D, 8'h0B, 16'h008F);

        // Request held through the done cycle is dropped there, then accepted one cycle later.
        drive(3'(OP_ADD), 8'h03, 8'h04);
        tick();
        check("b2b_done1", 32'(operation_done), 32'd1);
        check("b2b_res1", 32'(result), 32'h0007);
        tick();
        check("b2b_dropped", 32'(op_dropped), 32'd1);
        check("b2b_gap_done", 32'(operation_done), 32'd0);
        check("b2b_gap_busy", 32'(busy), 32'd0);
        operand_a = 8'h10;
        tick();
        op_valid = 1'b0;
        check("b2b_done2", 32'(operation_done), 32'd1);
        check("b2b_res2", 32'(result), 32'h0014);
        check("b2b_no_drop", 32'(op_dropped), 32'd0);
        tick();

        // Request during a multiply is dropped without disturbing it.
        drive(3'(OP_MUL), 8'hFF, 8'hFF);
        tick();
        op_valid = 1'b0;
        n = 0;
        repeat (2) begin
            tick();
            n++;
        end
        drive(3'(OP_ADD), 8'h01, 8'h02);
        tick();
        n++;
        op_valid = 1'b0;
        check("drop_pulse", 32'(op_dropped), 32'd1);
        check("drop_no_done", 32'(operation_done), 32'd0);
        tick();
        n++;
        check("drop_pulse_end", 32'(op_dropped), 32'd0);
        while (!operation_done && n < 30) begin
            tick();
            n++;
        end
        check("drop_mul_latency", 32'(n), 32'(WIDTH));
        check("drop_mul_result", 32'(result), 32'hFE01);
        tick();

        // Reset mid-multiply aborts it with no done pulse.
        drive(3'(OP_MUL), 8'hFF, 8'hFF);
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        resetr = 1'b0;
        tick();
        resetr = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(operation_done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (operation_done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        drive(3'(OP_ADD), 8'h02, 8'h03);
        tick();
        op_valid = 1'b0;
        check("post_abort_done", 32'(operation_done), 32'd1);
        check("post_abort_result", 32'(result), 32'h0005);
        tick();
        check("post_abort_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
